pixel_ray_dispatch: RTL and testbench
=====================================

Name: pixel_ray_dispatch

Overview:
- Frame-level initiator for the ray generator's start/done interface.
- On a frame start it walks every screen pixel in raster order and forms an un-normalized signed Q16.16 camera-space direction for each pixel.
- For each pixel it issues one ray generator request, captures the normalized direction it returns, and presents it downstream on a valid/ready stream tagged with the pixel coordinates.

Parameters:
- H_RES, 320, pixels per line
- V_RES, 180, lines per frame
- PIX_SHIFT, 8, left shift applied to a signed pixel offset to form the Q16.16 x/y component
- FOCAL, 32'h0001_0000, Q16.16 z component, constant for every ray
- TIMEOUT, 1024, maximum cycles spent waiting for ray_gen_done_in before aborting

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- frame_start_in  in  1  pulse: begin a frame; ignored while busy_out=1
- busy_out  out  1  high from the cycle after an accepted frame_start_in until the frame ends or aborts
- frame_done_out  out  1  one-cycle pulse after the last pixel is accepted downstream
- error_out  out  1  sticky ray generator timeout flag, cleared by reset or an accepted frame_start_in
- ray_gen_start_out  out  1  one-cycle request to the ray generator
- ray_gen_x_out / ray_gen_y_out / ray_gen_z_out  out  32 each  un-normalized direction operands, signed Q16.16
- ray_gen_done_in  in  1  ray generator result valid
- ray_gen_x_in / ray_gen_y_in / ray_gen_z_in  in  32 each  normalized direction returned by the ray generator
- ray_valid_out  out  1  downstream ray valid
- ray_ready_in  in  1  downstream ready
- ray_hcount_out  out  $clog2(H_RES)  pixel column of the presented ray
- ray_vcount_out  out  $clog2(V_RES)  pixel row of the presented ray
- ray_dir_x_out / ray_dir_y_out / ray_dir_z_out  out  32 each  captured normalized direction

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE and all outputs 0, including counters, operand registers, captured directions and error_out.
- States: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE:
  - frame_start_in=1 loads hcount=0, vcount=0, clears error_out and moves to ISSUE.
  - frame_done_out is 0 in IDLE except in the first cycle after leaving OUTPUT on the last pixel.
- ISSUE (exactly 1 cycle):
  - ray_gen_start_out=1.
  - ray_gen_x_out = sign-extended (hcount - H_RES/2) << PIX_SHIFT.
  - ray_gen_y_out = (V_RES/2 - vcount) << PIX_SHIFT.
  - ray_gen_z_out = FOCAL.
  - Operands are registered and held stable from ISSUE through the end of WAIT.
  - Next state is WAIT.
- WAIT:
  - ray_gen_start_out=0; the timeout counter increments each cycle.
  - ray_gen_done_in is sampled only in WAIT. When it is 1, capture ray_gen_x_in/y_in/z_in into ray_dir_*_out and go to OUTPUT.
  - If the counter reaches TIMEOUT with no done: set error_out=1, go to IDLE, deassert busy_out, no frame_done_out pulse.
  - A done asserted in the ISSUE cycle is ignored.
- OUTPUT:
  - ray_valid_out=1; ray_dir_*, ray_hcount_out and ray_vcount_out are held stable until the handshake.
  - On ray_valid_out & ray_ready_in, advance: hcount+1. At H_RES-1, hcount wraps to 0 and vcount+1.
  - If the accepted pixel was (H_RES-1, V_RES-1): pulse frame_done_out for one cycle, go to IDLE, deassert busy_out.
  - Otherwise go to ISSUE.
  - ray_valid_out never drops without a handshake.
- Throughput: with ready held high and a ray generator latency of L cycles (done in the L-th cycle after start), each pixel takes L+2 cycles.
- frame_start_in while busy: ignored; the frame is not restarted.
- Reset asserted mid-frame: immediate return to IDLE, outputs cleared; a late ray_gen_done_in after reset is ignored.

Test Plan:
- H_RES=4, V_RES=2, PIX_SHIFT=12, FOCAL=1<<16; stub ray generator returns done 3 cycles after start, echoing its inputs. Pulse frame_start_in -> first request x=32'hFFFF_E000, y=32'h0000_1000, z=32'h0001_0000; 8 rays in order (0,0)..(3,1); last ray y=32'h0000_0000, x=32'h0000_1000; single frame_done_out pulse; busy_out=0 afterward.
- Same config, ready held high -> ray_valid_out asserted every 5 cycles (L=3); ray_gen_start_out exactly 1 cycle per pixel; operands stable across WAIT.
- Downstream ready low for 10 cycles on pixel (1,0) -> ray_valid_out and data held unchanged for 10 cycles; no new ray_gen_start_out until the handshake.
- Stub never asserts done, TIMEOUT=16 -> after 16 WAIT cycles error_out=1, busy_out=0, no frame_done_out; a following frame_start_in clears error_out and restarts at (0,0).
- frame_start_in pulsed mid-frame -> ignored, pixel sequence continues. rst_in low mid-WAIT -> all outputs 0 asynchronously; a done pulse arriving after reset does not cause ray_valid_out.

Source files
------------

// File: rtl/pixel_ray_dispatch.sv
// pixel_ray_dispatch
//   Walks every pixel of a frame in raster order. For each pixel it forms an
//   un-normalized signed Q16.16 camera-space direction and issues one request
//   to the ray generator. It then captures the normalized direction that comes
//   back and presents it on a valid/ready stream, tagged with the pixel
//   coordinates.
//
// Ports
//   clk_in, rst_in (async, active-low)
//   frame_start_in                 : begins a frame; ignored while busy_out=1
//   busy_out, frame_done_out       : frame status; frame_done_out is a 1-cycle pulse
//   error_out                      : sticky ray generator timeout flag
//   ray_gen_start_out, ray_gen_{x,y,z}_out : request and operands to the ray generator
//   ray_gen_done_in, ray_gen_{x,y,z}_in    : ray generator result
//   ray_valid_out, ray_ready_in    : downstream handshake
//   ray_hcount_out, ray_vcount_out : pixel coordinates of the presented ray
//   ray_dir_{x,y,z}_out            : captured normalized direction
module pixel_ray_dispatch #(
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 180,
  parameter int          PIX_SHIFT = 8,
  parameter logic [31:0] FOCAL     = 32'h0001_0000,
  parameter int          TIMEOUT   = 1024,
  localparam int         HW        = $clog2(H_RES),
  localparam int         VW        = $clog2(V_RES)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 frame_start_in,
  output logic                 busy_out,
  output logic                 frame_done_out,
  output logic                 error_out,
  output logic                 ray_gen_start_out,
  output logic signed [31:0]   ray_gen_x_out,
  output logic signed [31:0]   ray_gen_y_out,
  output logic signed [31:0]   ray_gen_z_out,
  input  logic                 ray_gen_done_in,
  input  logic signed [31:0]   ray_gen_x_in,
  input  logic signed [31:0]   ray_gen_y_in,
  input  logic signed [31:0]   ray_gen_z_in,
  output logic                 ray_valid_out,
  input  logic                 ray_ready_in,
  output logic [HW-1:0]        ray_hcount_out,
  output logic [VW-1:0]        ray_vcount_out,
  output logic signed [31:0]   ray_dir_x_out,
  output logic signed [31:0]   ray_dir_y_out,
  output logic signed [31:0]   ray_dir_z_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hcount, h_nxt;
  logic [VW-1:0] vcount, v_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          accept;
  logic          last_pix;
  logic          frame_done_nxt;

  // Column offset from screen centre, scaled into Q16.16. Modular 32-bit
  // subtraction yields the correctly sign-extended two's-complement offset.
  function automatic logic signed [31:0] x_operand(input logic [HW-1:0] h);
    logic signed [31:0] off;
    off = signed'(32'(h) - 32'(H_RES / 2));
    return off <<< PIX_SHIFT;
  endfunction

  // Row offset, flipped so that +y points up the screen.
  function automatic logic signed [31:0] y_operand(input logic [VW-1:0] v);
    logic signed [31:0] off;
    off = signed'(32'(V_RES / 2) - 32'(v));
    return off <<< PIX_SHIFT;
  endfunction

  assign tmo_hit  = (state == WAIT) && !ray_gen_done_in && (tmo_cnt == TW'(TIMEOUT - 1));
  assign accept   = (state == OUTPUT) && ray_ready_in;
  assign last_pix = (hcount == HW'(H_RES - 1)) && (vcount == VW'(V_RES - 1));

  assign busy_out          = (state != IDLE);
  assign ray_gen_start_out = (state == ISSUE);
  assign ray_valid_out     = (state == OUTPUT);
  assign ray_hcount_out    = hcount;
  assign ray_vcount_out    = vcount;

  always_comb begin
    state_nxt      = state;
    h_nxt          = hcount;
    v_nxt          = vcount;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start_in) begin
          state_nxt = ISSUE;
          h_nxt     = '0;
          v_nxt     = '0;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (ray_gen_done_in) state_nxt = OUTPUT;
        else if (tmo_hit)    state_nxt = IDLE;
      end
      OUTPUT: begin
        if (accept) begin
          if (last_pix) begin
            state_nxt      = IDLE;
            frame_done_nxt = 1'b1;
          end else begin
            state_nxt = ISSUE;
            if (hcount == HW'(H_RES - 1)) begin
              h_nxt = '0;
              v_nxt = vcount + 1'b1;
            end else begin
              h_nxt = hcount + 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      hcount         <= '0;
      vcount         <= '0;
      tmo_cnt        <= '0;
      frame_done_out <= 1'b0;
      error_out      <= 1'b0;
      ray_gen_x_out  <= '0;
      ray_gen_y_out  <= '0;
      ray_gen_z_out  <= '0;
      ray_dir_x_out  <= '0;
      ray_dir_y_out  <= '0;
      ray_dir_z_out  <= '0;
    end else begin
      state          <= state_nxt;
      hcount         <= h_nxt;
      vcount         <= v_nxt;
      frame_done_out <= frame_done_nxt;

      if (state == IDLE && frame_start_in) error_out <= 1'b0;
      else if (tmo_hit)                    error_out <= 1'b1;

      tmo_cnt <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;

      // Operands are loaded on entry to ISSUE from the coordinates being
      // entered, so they are already valid in the ISSUE cycle and stay
      // untouched through WAIT.
      if (state_nxt == ISSUE) begin
        ray_gen_x_out <= x_operand(h_nxt);
        ray_gen_y_out <= y_operand(v_nxt);
        ray_gen_z_out <= FOCAL;
      end

      if (state == WAIT && ray_gen_done_in) begin
        ray_dir_x_out <= ray_gen_x_in;
        ray_dir_y_out <= ray_gen_y_in;
        ray_dir_z_out <= ray_gen_z_in;
      end
    end
  end

endmodule

// File: tb/tb_pixel_ray_dispatch.sv
// Bench for pixel_ray_dispatch: small 4x2 screen, ray generator stub with a
// programmable latency that returns its operands XORed with a per-frame salt.
module tb_pixel_ray_dispatch;

  localparam int          H    = 4;
  localparam int          V    = 2;
  localparam int          PS   = 12;
  localparam int          TMO  = 16;
  localparam int          NPIX = H * V;
  localparam logic [31:0] FOC  = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        ready = 1'b0;
  logic        busy, fdone, err, gstart, gdone, valid;
  logic [31:0] gx, gy, gz, rx, ry, rz, dx, dy, dz;
  logic [1:0]  hc;
  logic [0:0]  vc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ray generator stub
  int          stub_lat = 3;
  bit          stub_en  = 1'b1;
  logic [31:0] stub_xor = '0;
  int          stub_cnt = 0;
  logic [31:0] lat_x = '0, lat_y = '0, lat_z = '0;

  pixel_ray_dispatch #(
    .H_RES(H), .V_RES(V), .PIX_SHIFT(PS), .FOCAL(FOC), .TIMEOUT(TMO)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .frame_start_in(frame_start),
    .busy_out(busy), .frame_done_out(fdone), .error_out(err),
    .ray_gen_start_out(gstart),
    .ray_gen_x_out(gx), .ray_gen_y_out(gy), .ray_gen_z_out(gz),
    .ray_gen_done_in(gdone),
    .ray_gen_x_in(rx), .ray_gen_y_in(ry), .ray_gen_z_in(rz),
    .ray_valid_out(valid), .ray_ready_in(ready),
    .ray_hcount_out(hc), .ray_vcount_out(vc),
    .ray_dir_x_out(dx), .ray_dir_y_out(dy), .ray_dir_z_out(dz)
  );

  always #5 clk = ~clk;

  // done is raised in the stub_lat-th cycle after the start cycle
  always @(posedge clk) begin
    if (gstart) begin
      lat_x    <= gx;
      lat_y    <= gy;
      lat_z    <= gz;
      stub_cnt <= stub_lat;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign gdone = stub_en && (stub_cnt == 1);
  assign rx = gdone ? (lat_x ^ stub_xor) : ~lat_x;
  assign ry = gdone ? (lat_y ^ stub_xor) : ~lat_y;
  assign rz = gdone ? (lat_z ^ stub_xor) : ~lat_z;

  // reference: pixel index -> expected un-normalized direction
  function automatic logic [31:0] mdl_x(input int idx);
    return 32'(((idx % H) - H / 2) * (1 << PS));
  endfunction
  function automatic logic [31:0] mdl_y(input int idx);
    return 32'((V / 2 - idx / H) * (1 << PS));
  endfunction

  // Runs one complete frame and checks every request and every presented ray.
  task automatic run_frame(input int lat, input int pct, input bit chk_period,
                           input int hold_idx, input bit mid_start);
    int idx, cyc, nstart_pix, first_v, fd_cnt, hold_cnt;
    bit pend, ops_held;
    logic [31:0] ox, oy, oz, px, py, pz;
    logic [1:0]  ph;
    logic [0:0]  pv;
    idx = 0; cyc = 0; nstart_pix = 0; first_v = 0; fd_cnt = 0; hold_cnt = 0;
    pend = 1'b0; ops_held = 1'b0;
    ox = '0; oy = '0; oz = '0; px = '0; py = '0; pz = '0; ph = '0; pv = '0;
    stub_lat = lat; stub_en = 1'b1; stub_xor = $urandom;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    total_cnt++;
    if (err !== 1'b0 || busy !== 1'b1)
      $display("FAIL frame_accept: err=%b busy=%b, want err=0 busy=1", err, busy);
    else pass_cnt++;
    while (idx < NPIX && cyc < 3000) begin
      if (fdone) fd_cnt++;
      if (gstart) begin
        total_cnt++;
        if ({gx, gy, gz} !== {mdl_x(idx), mdl_y(idx), FOC} || nstart_pix != 0 || valid)
          $display("FAIL issue_operands pix %0d: x=%h y=%h z=%h starts=%0d valid=%b, want x=%h y=%h z=%h starts=0 valid=0",
                   idx, gx, gy, gz, nstart_pix, valid, mdl_x(idx), mdl_y(idx), FOC);
        else pass_cnt++;
        nstart_pix++;
        ox = gx; oy = gy; oz = gz; ops_held = 1'b1;
      end else if (ops_held && !valid) begin
        total_cnt++;
        if ({gx, gy, gz} !== {ox, oy, oz})
          $display("FAIL operand_hold pix %0d: x=%h y=%h z=%h, want x=%h y=%h z=%h",
                   idx, gx, gy, gz, ox, oy, oz);
        else pass_cnt++;
      end
      if (pend) begin
        total_cnt++;
        if (valid !== 1'b1 || {hc, vc, dx, dy, dz} !== {ph, pv, px, py, pz})
          $display("FAIL ray_held pix %0d: valid=%b h=%0d v=%0d x=%h y=%h z=%h, want valid=1 h=%0d v=%0d x=%h y=%h z=%h",
                   idx, valid, hc, vc, dx, dy, dz, ph, pv, px, py, pz);
        else pass_cnt++;
      end else if (valid) begin
        total_cnt++;
        if ({hc, vc, dx, dy, dz} !== {2'(idx % H), 1'(idx / H), mdl_x(idx) ^ stub_xor,
                                      mdl_y(idx) ^ stub_xor, FOC ^ stub_xor})
          $display("FAIL ray_data pix %0d: h=%0d v=%0d x=%h y=%h z=%h, want h=%0d v=%0d x=%h y=%h z=%h",
                   idx, hc, vc, dx, dy, dz, idx % H, idx / H, mdl_x(idx) ^ stub_xor,
                   mdl_y(idx) ^ stub_xor, FOC ^ stub_xor);
        else pass_cnt++;
        if (chk_period && idx > 0) begin
          total_cnt++;
          if (cyc - first_v != lat + 2)
            $display("FAIL ray_period pix %0d: %0d cycles, want %0d", idx, cyc - first_v, lat + 2);
          else pass_cnt++;
        end
        first_v = cyc;
      end
      if (valid && idx == hold_idx && hold_cnt < 10) begin
        ready = 1'b0;
        hold_cnt++;
      end else begin
        ready = ($urandom_range(99) < pct);
      end
      frame_start = mid_start && (cyc == 7);
      pend = valid && !ready;
      ph = hc; pv = vc; px = dx; py = dy; pz = dz;
      if (valid && ready) begin
        idx++;
        nstart_pix = 0;
        ops_held = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    ready = 1'b0;
    frame_start = 1'b0;
    total_cnt++;
    if (idx != NPIX) $display("FAIL frame_complete: %0d rays accepted, want %0d", idx, NPIX);
    else pass_cnt++;
    total_cnt++;
    if (fdone !== 1'b1 || busy !== 1'b0 || fd_cnt != 0)
      $display("FAIL frame_done_pulse: done=%b busy=%b early=%0d, want done=1 busy=0 early=0",
               fdone, busy, fd_cnt);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (fdone !== 1'b0 || busy !== 1'b0)
      $display("FAIL frame_done_single: done=%b busy=%b, want done=0 busy=0", fdone, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({busy, fdone, err, gstart, valid, hc, vc} !== '0 || {gx, gy, gz, dx, dy, dz} !== '0)
      $display("FAIL reset_state: busy=%b done=%b err=%b start=%b valid=%b gx=%h dx=%h, want all 0",
               busy, fdone, err, gstart, valid, gx, dx);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b, want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    run_frame(3, 100, 1'b1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(3, 100, 1'b0, 1, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++)
      run_frame(int'($urandom_range(6, 1)), 50, 1'b0, -1, 1'b0);
  endtask

  task automatic test_timeout();
    int n, fd;
    n = 0; fd = 0;
    stub_en = 1'b0;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    total_cnt++;
    if (gstart !== 1'b1) $display("FAIL timeout_issue: start=%b, want 1", gstart);
    else pass_cnt++;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
      if (fdone) fd++;
    end
    total_cnt++;
    if (n != TMO + 1 || err !== 1'b1 || fd != 0 || busy !== 1'b0)
      $display("FAIL timeout_abort: cycles=%0d err=%b done_pulses=%0d busy=%b, want cycles=%0d err=1 done_pulses=0 busy=0",
               n, err, fd, busy, TMO + 1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (err !== 1'b1) $display("FAIL error_sticky: err=%b, want 1", err);
    else pass_cnt++;
    stub_en = 1'b1;
    run_frame(2, 100, 1'b1, -1, 1'b0);
  endtask

  task automatic test_mid_frame_start();
    run_frame(2, 100, 1'b1, -1, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    seen = 0;
    stub_lat = 3; stub_en = 1'b1;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || gx === 32'h0)
      $display("FAIL wait_before_reset: busy=%b gx=%h, want busy=1 gx nonzero", busy, gx);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, fdone, err, gstart, valid, hc, vc} !== '0 || {gx, gy, gz, dx, dy, dz} !== '0)
      $display("FAIL async_reset: busy=%b start=%b valid=%b gx=%h gz=%h dx=%h dz=%h, want all 0",
               busy, gstart, valid, gx, gz, dx, dz);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid || busy) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL late_done_ignored: %0d active cycles, want 0", seen);
    else pass_cnt++;
    run_frame(3, 100, 1'b1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_random_frames();
    test_timeout();
    test_mid_frame_start();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
